counter_seq_checker: RTL and testbench

COUNTER_SEQ_CHECKER -- requirements
Module: counter_seq_checker

---
 rtl/counter_seq_checker.sv | 139 +++++++++++++
 tb/tb_counter_seq_checker.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
// Sequence checker for an upstream 4-bit counter (ring, johnson, decade or binary mod-16).
// Locks after LOCK_N consistent samples and flags each break while locked.
module counter_seq_checker #(
   parameter int unsigned LOCK_N = 4,
   parameter int unsigned ERR_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [3:0]       q,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

   localparam logic [3:0]       LockRun = 4'(LOCK_N);
   localparam logic [ERR_W-1:0] CntMax  = '1;

   state_e           state_q, state_d;
   logic [3:0]       prev_q, prev_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       run_inc;
   logic [1:0]       mode_q;
   logic             mode_vld_q;
   logic             mode_chg;
   logic             q_legal;
   logic             q_match;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   function automatic logic is_legal(input logic [1:0] m, input logic [3:0] p);
      logic r;
      unique case (m)
         2'b00:   r = (p == 4'b0001) || (p == 4'b0010) || (p == 4'b0100) || (p == 4'b1000);
         2'b01:   r = (p == 4'b0000) || (p == 4'b1000) || (p == 4'b1100) || (p == 4'b1110) ||
                      (p == 4'b1111) || (p == 4'b0111) || (p == 4'b0011) || (p == 4'b0001);
         2'b10:   r = (p <= 4'd9);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] next_of(input logic [1:0] m, input logic [3:0] p);
      logic [3:0] r;
      unique case (m)
         2'b00:   r = {p[2:0], p[3]};
         2'b01:   r = {~p[0], p[3:1]};
         2'b10:   r = (p == 4'd9) ? 4'd0 : p + 4'd1;
         default: r = p + 4'd1;
      endcase
      return r;
   endfunction

   // The first edge after reset only loads the mode register; it is not a mode change.
   assign mode_chg = mode_vld_q && (mode != mode_q);
   assign q_legal  = is_legal(mode, q);
   assign q_match  = (q == next_of(mode, prev_q));
   assign run_inc  = run_q + 4'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StUnlocked;
         prev_q     <= 4'd0;
         run_q      <= 4'd0;
         mode_q     <= 2'b00;
         mode_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         run_q      <= run_d;
         mode_q     <= mode;
         mode_vld_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      run_d   = run_q;
      if (mode_chg) begin
         state_d = StUnlocked;
      end else if (en) begin
         unique case (state_q)
            StUnlocked: begin
               if (q_legal) begin
                  prev_d  = q;
                  run_d   = 4'd1;
                  state_d = StAcquire;
               end
            end
            StAcquire: begin
               if (q_match) begin
                  prev_d = q;
                  run_d  = run_inc;
                  if (run_inc == LockRun) state_d = StLocked;
               end else if (q_legal) begin
                  prev_d = q;
                  run_d  = 4'd1;
               end else begin
                  state_d = StUnlocked;
               end
            end
            StLocked: begin
               if (q_match) prev_d = q;
               else         state_d = StUnlocked;
            end
            default: state_d = StUnlocked;
         endcase
      end
   end

   always_comb begin
      err_d       = !mode_chg && en && (state_q == StLocked) && !q_match;
      locked_d    = (state_d == StLocked);
      err_count_d = err_count_q;
      if (err_d && (err_count_q != CntMax)) err_count_d = err_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker: one default instance and one with a 2-bit error counter,
// both driven by the same stimulus.
module tb_counter_seq_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [1:0] mode;
   logic [3:0] q;
   logic       locked8, err8, locked2, err2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   counter_seq_checker #(.LOCK_N(4), .ERR_W(8)) dut8 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .q(q),
      .locked(locked8), .err(err8), .err_count(cnt8)
   );

   counter_seq_checker #(.LOCK_N(4), .ERR_W(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .q(q),
      .locked(locked2), .err(err2), .err_count(cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs of both instances against expected locked/err and per-instance counts.
   task automatic chk_all(input string tag, input logic l, input logic e,
                          input logic [7:0] c8, input logic [1:0] c2);
      chk({tag, ".locked8"}, 32'(locked8), 32'(l));
      chk({tag, ".err8"},    32'(err8),    32'(e));
      chk({tag, ".cnt8"},    32'(cnt8),    32'(c8));
      chk({tag, ".locked2"}, 32'(locked2), 32'(l));
      chk({tag, ".err2"},    32'(err2),    32'(e));
      chk({tag, ".cnt2"},    32'(cnt2),    32'(c2));
   endtask

   // Apply one sample, then sample outputs 1 time unit after the edge.
   task automatic step(input logic e, input logic [1:0] m, input logic [3:0] v);
      en   = e;
      mode = m;
      q    = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      en    = 1'b0;
      mode  = 2'b00;
      q     = 4'd0;
      #1;
      chk_all("reset_async", 1'b0, 1'b0, 8'd0, 2'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset_hold", 1'b0, 1'b0, 8'd0, 2'd0);
      reset = 1'b1;

      // Decade lock; first edge after release is a normal evaluation edge.
      step(1'b1, 2'b10, 4'd0);
      step(1'b1, 2'b10, 4'd1);
      step(1'b1, 2'b10, 4'd2);
      chk_all("dec_run3", 1'b0, 1'b0, 8'd0, 2'd0);
      step(1'b1, 2'b10, 4'd3);
      chk_all("dec_lock", 1'b1, 1'b0, 8'd0, 2'd0);
      for (int i = 4; i <= 10; i++) begin
         step(1'b1, 2'b10, 4'((i == 10) ? 0 : i));
         chk_all($sformatf("dec_track%0d", i), 1'b1, 1'b0, 8'd0, 2'd0);
      end

      // Ring: mode change edge is discarded, then lock, break, relock.
      step(1'b1, 2'b00, 4'b0001);
      chk_all("ring_modechg", 1'b0, 1'b0, 8'd0, 2'd0);
      step(1'b1, 2'b00, 4'b0001);
      step(1'b1, 2'b00, 4'b0010);
      step(1'b1, 2'b00, 4'b0100);
      chk_all("ring_run3", 1'b0, 1'b0, 8'd0, 2'd0);
      step(1'b1, 2'b00, 4'b1000);
      chk_all("ring_lock", 1'b1, 1'b0, 8'd0, 2'd0);
      step(1'b1, 2'b00, 4'b0011);
      chk_all("ring_break", 1'b0, 1'b1, 8'd1, 2'd1);
      step(1'b1, 2'b00, 4'b0001);
      chk_all("ring_err_once", 1'b0, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b00, 4'b0010);
      step(1'b1, 2'b00, 4'b0100);
      step(1'b1, 2'b00, 4'b1000);
      chk_all("ring_relock", 1'b1, 1'b0, 8'd1, 2'd1);

      // Johnson: mode change with en=0, then full cycle including the wrap.
      step(1'b0, 2'b01, 4'b0000);
      chk_all("john_modechg", 1'b0, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b01, 4'b0000);
      step(1'b1, 2'b01, 4'b1000);
      step(1'b1, 2'b01, 4'b1100);
      chk_all("john_run3", 1'b0, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b01, 4'b1110);
      chk_all("john_lock", 1'b1, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b01, 4'b1111);
      step(1'b1, 2'b01, 4'b0111);
      step(1'b1, 2'b01, 4'b0011);
      step(1'b1, 2'b01, 4'b0001);
      chk_all("john_0001", 1'b1, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b01, 4'b0000);
      chk_all("john_wrap", 1'b1, 1'b0, 8'd1, 2'd1);

      // Binary: gaps keep lock, then a mode change unlocks without err.
      step(1'b0, 2'b11, 4'd0);
      step(1'b1, 2'b11, 4'd5);
      step(1'b1, 2'b11, 4'd6);
      step(1'b1, 2'b11, 4'd7);
      step(1'b1, 2'b11, 4'd8);
      chk_all("bin_lock", 1'b1, 1'b0, 8'd1, 2'd1);
      step(1'b0, 2'b11, 4'd3);
      step(1'b0, 2'b11, 4'd3);
      step(1'b0, 2'b11, 4'd3);
      chk_all("bin_gap", 1'b1, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b11, 4'd9);
      chk_all("bin_after_gap", 1'b1, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b10, 4'd12);
      chk_all("bin_modechg", 1'b0, 1'b0, 8'd1, 2'd1);

      // Decade: stalled value breaks lock; illegal value keeps it unlocked.
      for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 4'(i));
      chk_all("stall_lock", 1'b1, 1'b0, 8'd1, 2'd1);
      step(1'b1, 2'b10, 4'd3);
      chk_all("stall_break", 1'b0, 1'b1, 8'd2, 2'd2);
      step(1'b1, 2'b10, 4'd12);
      chk_all("illegal_unlocked", 1'b0, 1'b0, 8'd2, 2'd2);

      // Three more breaks: the 2-bit counter saturates at 3.
      for (int b = 3; b <= 5; b++) begin
         for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 4'(i));
         step(1'b1, 2'b10, 4'd7);
         chk_all($sformatf("sat_break%0d", b), 1'b0, 1'b1, 8'(b), 2'd3);
      end

      // Reset asserted between edges while err is high: outputs clear at once.
      for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 4'(i));
      step(1'b1, 2'b10, 4'd9);
      chk_all("pre_reset_break", 1'b0, 1'b1, 8'd6, 2'd3);
      #2;
      reset = 1'b0;
      #1;
      chk_all("mid_reset", 1'b0, 1'b0, 8'd0, 2'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Reload of a non-00 mode on the first edge is not a mode change.
      step(1'b1, 2'b11, 4'd4);
      step(1'b1, 2'b11, 4'd5);
      step(1'b1, 2'b11, 4'd6);
      chk_all("post_reset_run3", 1'b0, 1'b0, 8'd0, 2'd0);
      step(1'b1, 2'b11, 4'd7);
      chk_all("post_reset_lock", 1'b1, 1'b0, 8'd0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
